stream_capture_reader: RTL and testbench

- Reader-side endpoint for the WIDTH-bit result stream produced by the team's datapath blocks.
- Captures each qualified output word into a DEPTH-entry circular buffer.
- Presents stored words in order on a valid/ready read port, first-word-fall-through.
- Tracks occupancy, overflow, and dropped-word count, so benches and downstream logic can drain results at their own rate.

---
 rtl/stream_capture_reader.sv | 67 ++++++
 tb/tb_stream_capture_reader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stream_capture_reader.sv
// Capture buffer for a datapath result stream.
// Circular FIFO with FWFT read port, overflow flag and drop counter.
module stream_capture_reader #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap_en,
  input  logic              cap_valid,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;
  logic              flush;

  assign flush    = rst | clr;
  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign push     = cap_en & cap_valid & ~full;
  assign drop     = cap_en & cap_valid & full;
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push & ~pop: count <= count + 1'b1;
        pop & ~push: count <= count - 1'b1;
        default:     count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Storage is left unreset; it is only observed while rd_valid is high.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_stream_capture_reader.sv
// Scoreboard bench for stream_capture_reader.
// Driver keeps a queue model; monitor checks status and read words.
module tb_stream_capture_reader;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DROP_W = 8;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              cap_en = 1'b0;
  logic              cap_valid = 1'b0;
  logic [WIDTH-1:0]  data_in = '0;
  logic              rd_ready = 1'b0;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  stream_capture_reader #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .cap_en(cap_en), .cap_valid(cap_valid), .data_in(data_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit ovf;
    int drp;
  } stat_t;

  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] expq[$];
  stat_t            stq[$];
  bit               ovf_m = 0;
  int               drop_m = 0;
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(bit r, bit c, bit e, bit v,
                      logic [WIDTH-1:0] d, bit rr);
    bit was_full;
    @(posedge clk);
    #1;
    stq.push_back('{model.size(), ovf_m, drop_m});
    rst = r; clr = c; cap_en = e; cap_valid = v;
    data_in = d; rd_ready = rr;
    if (r || c) begin
      model.delete();
      ovf_m = 0;
      drop_m = 0;
    end else begin
      was_full = (model.size() == DEPTH);
      if (rr && model.size() > 0) expq.push_back(model.pop_front());
      if (e && v) begin
        if (was_full) begin
          ovf_m = 1;
          if (drop_m < DMAX) drop_m++;
        end else begin
          model.push_back(d);
        end
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
  endtask

  always @(negedge clk) begin
    stat_t s;
    logic [WIDTH-1:0] w;
    if (stq.size() > 0) begin
      s = stq.pop_front();
      chk("count", int'(count), s.cnt);
      chk("rd_valid", int'(rd_valid), int'(s.cnt != 0));
      chk("full", int'(full), int'(s.cnt == DEPTH));
      chk("overflow", int'(overflow), int'(s.ovf));
      chk("drop_cnt", int'(drop_cnt), s.drp);
      if (s.cnt == 0) chk("rd_data_idle", int'(rd_data), 0);
    end
    if (!rst && !clr && rd_valid && rd_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_pop", int'(rd_data), -1);
      end else begin
        w = expq.pop_front();
        chk("rd_data", int'(rd_data), int'(w));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] seq;
    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    idle(1);

    step(0, 0, 1, 1, 8'h11, 0);
    step(0, 0, 1, 1, 8'h22, 0);
    step(0, 0, 1, 1, 8'h33, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, 1);
    idle(2);

    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 8'hA0 + 8'(i), 0);
    step(0, 0, 1, 1, 8'hFF, 0);
    step(0, 0, 1, 1, 8'hFF, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, '0, 1);
    idle(1);

    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 8'hA0 + 8'(i), 0);
    step(0, 0, 1, 1, 8'h55, 1);
    idle(1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, '0, 1);

    step(0, 1, 0, 0, '0, 0);
    seq = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, seq, 0);
      seq++;
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 1, seq, 1);
      seq++;
    end
    idle(1);

    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'hC0 + 8'(i), 0);
    for (int i = 0; i < 300; i++) step(0, 0, 1, 1, 8'(i), 0);
    step(0, 1, 1, 1, 8'h77, 1);
    idle(2);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'h31 + 8'(i), 0);
    step(0, 0, 0, 0, '0, 1);
    step(1, 0, 1, 1, 8'hEE, 1);
    step(0, 0, 0, 0, '0, 1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
           8'($urandom), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0, 1);
    idle(1);
    @(negedge clk);
    #1;
    chk("exp_q_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
